gcd_requester: RTL and testbench

GCD_REQUESTER -- requirements
Module: gcd_requester

---
 rtl/gcd_requester.sv | 164 ++++++++++++++++
 tb/tb_gcd_requester.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_requester.sv
// Purpose: sequences one GCD job at a time: accepts an operand pair, strobes the controller, returns the result.
// Latency: result valid 1 cycle after acceptance (zero operand) or 1 cycle after op_enb is sampled.
// Backpressure: single job in flight; in_ready only in IDLE; result held in OUT until out_ready.
// Optional feature: define GCD_REQ_TIMEOUT_EN to bound the controller wait with TIMEOUT_CYCLES.
module gcd_requester #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             go,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic             done,
    input  logic             op_enb,
    input  logic [WIDTH-1:0] gcd_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_RES = 3'd3,
        OUT      = 3'd4
    } state_t;

    state_t state, state_n;
    logic   accept;
    logic   bypass;
    logic   capture;
    logic   timeout_hit;
    logic   limit_reached;

    assign in_ready  = (state == IDLE) && rst;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign bypass    = (in_a == '0) || (in_b == '0);

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign limit_reached = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign out_err       = err_q;

    // Count cycles spent waiting on the controller; restarts whenever a job is issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (go) begin
            wait_cnt <= '0;
        end else if ((state == WAIT_ACK) || (state == WAIT_RES)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Error flag travels with the result: set on timeout, cleared by any real result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept || capture) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign limit_reached  = 1'b0;
    assign out_err        = 1'b0;
    assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and strobes; op_enb in WAIT_RES beats a timeout landing on the same cycle.
    always_comb begin
        state_n     = state;
        go          = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_n = bypass ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                if (done && rst) begin
                    go      = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (limit_reached) begin
                    timeout_hit = 1'b1;
                    state_n     = OUT;
                end else if (!done) begin
                    state_n = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (op_enb) begin
                    capture = 1'b1;
                    state_n = OUT;
                end else if (limit_reached) begin
                    timeout_hit = 1'b1;
                    state_n     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand latch: held for the whole job so the datapath load muxes see stable values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (accept) begin
            op_a <= in_a;
            op_b <= in_b;
        end
    end

    // Result register: zero-operand bypass, controller result, or zero on timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_gcd <= '0;
        end else if (accept && bypass) begin
            out_gcd <= in_a | in_b;
        end else if (capture) begin
            out_gcd <= gcd_res;
        end else if (timeout_hit) begin
            out_gcd <= '0;
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a small behavioural GCD controller model.
// Controller: idle/finish raise done, finish raises op_enb, busy phase lasts 3 cycles.
// Knobs: hold_done_low forces done low, hang keeps the controller busy forever.
module tb_gcd_requester;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         go;
    logic [W-1:0] op_a, op_b;
    logic         done;
    logic         op_enb;
    logic [W-1:0] gcd_res;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         out_err;
    logic         busy;

    logic         hold_done_low;
    logic         hang;

    int nvec = 0;
    int nerr = 0;

    gcd_requester #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .go(go), .op_a(op_a), .op_b(op_b),
        .done(done), .op_enb(op_enb), .gcd_res(gcd_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Controller model
    typedef enum logic [1:0] {C_IDLE, C_BUSY, C_FIN} cst_t;
    cst_t         cst;
    int           ccnt;
    logic [W-1:0] cres;

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            cst  <= C_IDLE;
            ccnt <= 0;
            cres <= '0;
        end else begin
            case (cst)
                C_IDLE, C_FIN: if (go) begin
                    cst  <= C_BUSY;
                    ccnt <= 3;
                    cres <= euclid(op_a, op_b);
                end
                C_BUSY: if (!hang) begin
                    if (ccnt <= 1) cst <= C_FIN;
                    else ccnt <= ccnt - 1;
                end
                default: cst <= C_IDLE;
            endcase
        end
    end

    assign done    = (cst != C_BUSY) && !hold_done_low;
    assign op_enb  = (cst == C_FIN);
    assign gcd_res = (cst == C_FIN) ? cres : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic accept_pair(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        chk({tag, " in_ready idle"}, 32'(in_ready), 1);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
        chk({tag, " op_a"}, 32'(op_a), 32'(a));
        chk({tag, " op_b"}, 32'(op_b), 32'(b));
    endtask

    task automatic wait_out(output int n, output int gos, output logic prev_enb);
        n = 0; gos = 0; prev_enb = 1'b0;
        while (!out_valid && n < 200) begin
            gos += int'(go);
            prev_enb = op_enb;
            tick();
            n++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid dropped"}, 32'(out_valid), 0);
        chk({tag, " in_ready after"}, 32'(in_ready), 1);
    endtask

    task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp,
                          input int exp_go, input int hold, input string tag);
        int n, gos;
        logic prev_enb;
        accept_pair(a, b, tag);
        wait_out(n, gos, prev_enb);
        chk({tag, " reached OUT"}, 32'(n < 200), 1);
        chk({tag, " go pulses"}, 32'(gos), 32'(exp_go));
        if (exp_go == 0) chk({tag, " bypass latency"}, 32'(n), 0);
        else chk({tag, " op_enb before out"}, 32'(prev_enb), 1);
        chk({tag, " out_gcd"}, 32'(out_gcd), 32'(exp));
        chk({tag, " out_err"}, 32'(out_err), 0);
        chk({tag, " busy"}, 32'(busy), 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold valid"}, 32'(out_valid), 1);
            chk({tag, " hold gcd"}, 32'(out_gcd), 32'(exp));
            chk({tag, " hold in_ready"}, 32'(in_ready), 0);
        end
        handshake(tag);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        tick();
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " go"}, 32'(go), 0);
        chk({tag, " in_ready in reset"}, 32'(in_ready), 0);
        rst = 1'b1;
        hang = 1'b0;
        #1;
        chk({tag, " in_ready idle"}, 32'(in_ready), 1);
    endtask

    initial begin
        int n, gos;
        logic prev_enb;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        hold_done_low = 1'b0; hang = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst go", 32'(go), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst op_a", 32'(op_a), 0);
        chk("rst op_b", 32'(op_b), 0);
        chk("rst out_gcd", 32'(out_gcd), 0);
        chk("rst out_err", 32'(out_err), 0);
        rst = 1'b1;
        tick();

        // Normal job and zero bypasses
        do_job(8'd12, 8'd8, 8'd4, 1, 0, "j12_8");
        do_job(8'd0, 8'd9, 8'd9, 0, 0, "j0_9");
        do_job(8'd0, 8'd0, 8'd0, 0, 0, "j0_0");
        do_job(8'd35, 8'd21, 8'd7, 1, 5, "j35_21");

        // done held low in ISSUE
        hold_done_low = 1'b1;
        accept_pair(8'd48, 8'd18, "dlow");
        for (int i = 0; i < 3; i++) begin
            chk("dlow go low", 32'(go), 0);
            chk("dlow busy", 32'(busy), 1);
            tick();
        end
        hold_done_low = 1'b0;
        #1;
        chk("dlow go pulse", 32'(go), 1);
        tick();
        chk("dlow go single", 32'(go), 0);
        wait_out(n, gos, prev_enb);
        chk("dlow reached OUT", 32'(n < 200), 1);
        chk("dlow out_gcd", 32'(out_gcd), 6);
        handshake("dlow");

        // Controller never finishes
        hang = 1'b1;
        accept_pair(8'd100, 8'd75, "hang");
        chk("hang go", 32'(go), 1);
        tick();
`ifdef GCD_REQ_TIMEOUT_EN
        wait_out(n, gos, prev_enb);
        chk("tmo cycles", 32'(n), 16);
        chk("tmo out_err", 32'(out_err), 1);
        chk("tmo out_gcd", 32'(out_gcd), 0);
        handshake("tmo");
`else
        for (int i = 0; i < 40; i++) tick();
        chk("hang out_valid", 32'(out_valid), 0);
        chk("hang busy", 32'(busy), 1);
        chk("hang in_ready", 32'(in_ready), 0);
`endif
        reset_pulse("hang rst");

        // Reset during WAIT_RES, then a fresh job
        hang = 1'b1;
        accept_pair(8'd20, 8'd5, "midrst");
        tick(); tick(); tick();
        chk("midrst busy", 32'(busy), 1);
        chk("midrst out_valid", 32'(out_valid), 0);
        reset_pulse("midrst rst");
        chk("midrst op_a cleared", 32'(op_a), 0);
        do_job(8'd9, 8'd6, 8'd3, 1, 0, "j9_6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
